// File: rtl/reg_mask_encoder_pkg.sv
// Shared register-file constants and encoder state type.
// Index and mux-select widths follow from the 16-entry register file.
package reg_mask_encoder_pkg;

   localparam int NREG      = 16;
   localparam int REG_IDX_W = 4;
   localparam int REG_SEL_W = 5;

   localparam logic [REG_SEL_W-1:0] SEL_NONE = 5'b00000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } enc_state_t;

   // Mux-select code reserves 0 for "no register", so index n maps to n+1.
   function automatic logic [REG_SEL_W-1:0] idx_to_sel(input logic [REG_IDX_W-1:0] idx);
      return {1'b0, idx} + REG_SEL_W'(1);
   endfunction

endpackage

// File: rtl/reg_mask_encoder_if.sv
// Request/beat bus between the controller, the mask encoder and the register-file port logic.
// The encoder sits on the slave modport.
interface reg_mask_encoder_if
   import reg_mask_encoder_pkg::*;
   ();

   logic                 req_valid;
   logic [NREG-1:0]      req_mask;
   logic                 req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [REG_IDX_W-1:0] out_idx;
   logic [REG_SEL_W-1:0] out_sel;
   logic                 out_last;
   logic [REG_SEL_W-1:0] out_count;
   logic                 done;
   logic                 empty_err;
   logic                 busy;

   modport master (
      output req_valid, req_mask, out_ready,
      input  req_ready, out_valid, out_idx, out_sel, out_last, out_count, done, empty_err, busy
   );

   modport slave (
      input  req_valid, req_mask, out_ready,
      output req_ready, out_valid, out_idx, out_sel, out_last, out_count, done, empty_err, busy
   );

endinterface

// File: rtl/reg_mask_encoder_prio_enc16.sv
// Combinational 16-to-4 priority encoder with selectable scan direction.
// Also yields the one-hot bit to clear and a flag for exactly one bit remaining.
module prio_enc16
   import reg_mask_encoder_pkg::*;
   (
   input  logic [NREG-1:0]      i_mask,
   input  logic                 i_lsb_first,
   output logic [REG_IDX_W-1:0] o_idx,
   output logic [NREG-1:0]      o_onehot,
   output logic                 o_single
   );

   logic w_any;

   // The last match in scan order wins, so scanning downward selects the lowest set bit.
   always_comb begin
      o_idx = '0;
      if (i_lsb_first) begin
         for (int i = NREG - 1; i >= 0; i--)
            if (i_mask[i]) o_idx = REG_IDX_W'(i);
      end else begin
         for (int i = 0; i < NREG; i++)
            if (i_mask[i]) o_idx = REG_IDX_W'(i);
      end
   end

   assign w_any    = (i_mask != '0);
   assign o_onehot = w_any ? (NREG'(1) << o_idx) : '0;
   assign o_single = w_any && ((i_mask & (i_mask - NREG'(1))) == '0);

endmodule

// File: rtl/reg_mask_encoder.sv
// Serializes a multi-hot register mask into one register index per handshake,
// for bulk save/restore and writeback replay.
module reg_mask_encoder
   import reg_mask_encoder_pkg::*;
   #(
   parameter bit LSB_FIRST = 1'b1,
   parameter int NREG      = 16
   )
   (
   input  logic              clk,
   input  logic              reset,
   reg_mask_encoder_if.slave bus
   );

   enc_state_t           r_state;
   logic [NREG-1:0]      r_pending;
   logic [REG_SEL_W-1:0] r_count;
   logic                 r_done;
   logic                 r_empty_err;

   logic [REG_IDX_W-1:0] w_idx;
   logic [NREG-1:0]      w_onehot;
   logic                 w_single;
   logic                 w_emit;

   prio_enc16 u_prio (
      .i_mask      (r_pending),
      .i_lsb_first (LSB_FIRST),
      .o_idx       (w_idx),
      .o_onehot    (w_onehot),
      .o_single    (w_single)
   );

   assign w_emit = (r_state == ST_EMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pending   <= '0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_empty_err <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_empty_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (bus.req_mask != '0) begin
                     r_pending <= bus.req_mask;
                     r_count   <= '0;
                     r_state   <= ST_EMIT;
                  end else begin
                     r_empty_err <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  r_pending <= r_pending & ~w_onehot;
                  r_count   <= r_count + REG_SEL_W'(1);
                  if (w_single) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Beat fields are gated so the select code reads "no register" outside a burst.
   assign bus.req_ready = !w_emit;
   assign bus.busy      = w_emit;
   assign bus.out_valid = w_emit;
   assign bus.out_idx   = w_emit ? w_idx : '0;
   assign bus.out_sel   = w_emit ? idx_to_sel(w_idx) : SEL_NONE;
   assign bus.out_last  = w_emit && w_single;
   assign bus.out_count = r_count;
   assign bus.done      = r_done;
   assign bus.empty_err = r_empty_err;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed bench for reg_mask_encoder: one LSB-first and one MSB-first instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_mask_encoder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   reg_mask_encoder_if bl ();
   reg_mask_encoder_if bm ();

   reg_mask_encoder #(.LSB_FIRST(1'b1), .NREG(16)) dut_l (.clk(clk), .reset(reset), .bus(bl.slave));
   reg_mask_encoder #(.LSB_FIRST(1'b0), .NREG(16)) dut_m (.clk(clk), .reset(reset), .bus(bm.slave));

   always #5 clk = ~clk;

   task automatic test_reset();
      bl.req_valid = 1'b0; bl.req_mask = '0; bl.out_ready = 1'b1;
      bm.req_valid = 1'b0; bm.req_mask = '0; bm.out_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.busy, bl.done, bl.empty_err, bl.out_count} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%0b idx=%0d sel=%0d last=%0b busy=%0b done=%0b err=%0b cnt=%0d, expected all 0",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.busy, bl.done, bl.empty_err, bl.out_count);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bl.req_ready !== 1'b1 || bm.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_req_ready: got %0b/%0b, expected 1/1", bl.req_ready, bm.req_ready);
      end
   endtask

   task automatic test_basic();
      bl.req_valid = 1'b1; bl.req_mask = 16'h0005; bl.out_ready = 1'b1;
      @(negedge clk);
      bl.req_valid = 1'b0;
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.req_ready, bl.busy} !== {1'b1, 4'd0, 5'd1, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL basic_beat0: got v=%0b idx=%0d sel=%0d last=%0b rdy=%0b busy=%0b, expected 1 0 1 0 0 1",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.req_ready, bl.busy);
      end
      @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.out_count} !== {1'b1, 4'd2, 5'd3, 1'b1, 5'd1}) begin
         errors++;
         $display("FAIL basic_beat1: got v=%0b idx=%0d sel=%0d last=%0b cnt=%0d, expected 1 2 3 1 1",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.out_count);
      end
      @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.out_sel, bl.done, bl.out_count, bl.req_ready} !== {1'b0, 5'd0, 1'b1, 5'd2, 1'b1}) begin
         errors++;
         $display("FAIL basic_done: got v=%0b sel=%0d done=%0b cnt=%0d rdy=%0b, expected 0 0 1 2 1",
                  bl.out_valid, bl.out_sel, bl.done, bl.out_count, bl.req_ready);
      end
      @(negedge clk);
      checks++;
      if (bl.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%0b, expected 0", bl.done);
      end
   endtask

   task automatic test_full();
      bl.req_valid = 1'b1; bl.req_mask = 16'hFFFF; bl.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bl.req_valid = 1'b0;
         checks++;
         if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.out_count} !==
             {1'b1, 4'(i), 5'(i + 1), (i == 15), 5'(i)}) begin
            errors++;
            $display("FAIL full_beat%0d: got v=%0b idx=%0d sel=%0d last=%0b cnt=%0d, expected 1 %0d %0d %0b %0d",
                     i, bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.out_count, i, i + 1, (i == 15), i);
         end
      end
      @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.done, bl.out_count} !== {1'b0, 1'b1, 5'd16}) begin
         errors++;
         $display("FAIL full_done: got v=%0b done=%0b cnt=%0d, expected 0 1 16", bl.out_valid, bl.done, bl.out_count);
      end
      @(negedge clk);
      checks++;
      if (bl.out_count !== 5'd16) begin
         errors++;
         $display("FAIL full_count_hold: got cnt=%0d, expected 16", bl.out_count);
      end
   endtask

   task automatic test_backpressure();
      bl.req_valid = 1'b1; bl.req_mask = 16'h8001; bl.out_ready = 1'b1;
      @(negedge clk);
      bl.req_valid = 1'b0;
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last} !== {1'b1, 4'd0, 5'd1, 1'b0}) begin
         errors++;
         $display("FAIL bp_beat0: got v=%0b idx=%0d sel=%0d last=%0b, expected 1 0 1 0",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last);
      end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         bl.out_ready = (s == 2);
         checks++;
         if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.done, bl.out_count} !==
             {1'b1, 4'd15, 5'd16, 1'b1, 1'b0, 5'd1}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%0b idx=%0d sel=%0d last=%0b done=%0b cnt=%0d, expected 1 15 16 1 0 1",
                     s, bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.done, bl.out_count);
         end
      end
      @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.done, bl.out_count} !== {1'b0, 1'b1, 5'd2}) begin
         errors++;
         $display("FAIL bp_done: got v=%0b done=%0b cnt=%0d, expected 0 1 2", bl.out_valid, bl.done, bl.out_count);
      end
      @(negedge clk);
      checks++;
      if (bl.done !== 1'b0) begin
         errors++;
         $display("FAIL bp_done_once: got done=%0b, expected 0", bl.done);
      end
   endtask

   task automatic test_empty();
      bl.req_valid = 1'b1; bl.req_mask = 16'h0000;
      @(negedge clk);
      bl.req_valid = 1'b0;
      checks++;
      if ({bl.empty_err, bl.out_valid, bl.done, bl.req_ready, bl.busy} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL empty_pulse: got err=%0b v=%0b done=%0b rdy=%0b busy=%0b, expected 1 0 0 1 0",
                  bl.empty_err, bl.out_valid, bl.done, bl.req_ready, bl.busy);
      end
      @(negedge clk);
      checks++;
      if ({bl.empty_err, bl.out_valid, bl.done, bl.req_ready} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL empty_after: got err=%0b v=%0b done=%0b rdy=%0b, expected 0 0 0 1",
                  bl.empty_err, bl.out_valid, bl.done, bl.req_ready);
      end
   endtask

   task automatic test_reset_mid();
      bl.req_valid = 1'b1; bl.req_mask = 16'h00F0; bl.out_ready = 1'b1;
      @(negedge clk);
      bl.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bl.out_idx, bl.out_count} !== {4'd5, 5'd1}) begin
         errors++;
         $display("FAIL rst_mid_beat1: got idx=%0d cnt=%0d, expected 5 1", bl.out_idx, bl.out_count);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.busy, bl.done, bl.out_count} !== 14'd0) begin
         errors++;
         $display("FAIL rst_mid_async: got v=%0b idx=%0d sel=%0d last=%0b busy=%0b done=%0b cnt=%0d, expected all 0",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last, bl.busy, bl.done, bl.out_count);
      end
      @(negedge clk);
      reset = 1'b0;
      bl.req_valid = 1'b1; bl.req_mask = 16'h0002;
      @(negedge clk);
      bl.req_valid = 1'b0;
      checks++;
      if ({bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last} !== {1'b1, 4'd1, 5'd2, 1'b1}) begin
         errors++;
         $display("FAIL rst_mid_next: got v=%0b idx=%0d sel=%0d last=%0b, expected 1 1 2 1",
                  bl.out_valid, bl.out_idx, bl.out_sel, bl.out_last);
      end
      @(negedge clk);
      checks++;
      if ({bl.out_valid, bl.done, bl.out_count} !== {1'b0, 1'b1, 5'd1}) begin
         errors++;
         $display("FAIL rst_mid_done: got v=%0b done=%0b cnt=%0d, expected 0 1 1", bl.out_valid, bl.done, bl.out_count);
      end
   endtask

   task automatic test_msb_first();
      bm.req_valid = 1'b1; bm.req_mask = 16'h0300; bm.out_ready = 1'b1;
      @(negedge clk);
      bm.req_mask = 16'h0001;
      checks++;
      if ({bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.req_ready} !== {1'b1, 4'd9, 5'd10, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL msb_beat0: got v=%0b idx=%0d sel=%0d last=%0b rdy=%0b, expected 1 9 10 0 0",
                  bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.req_ready} !== {1'b1, 4'd8, 5'd9, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL msb_beat1: got v=%0b idx=%0d sel=%0d last=%0b rdy=%0b, expected 1 8 9 1 0",
                  bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({bm.out_valid, bm.done, bm.req_ready, bm.out_count} !== {1'b0, 1'b1, 1'b1, 5'd2}) begin
         errors++;
         $display("FAIL msb_done: got v=%0b done=%0b rdy=%0b cnt=%0d, expected 0 1 1 2",
                  bm.out_valid, bm.done, bm.req_ready, bm.out_count);
      end
      @(negedge clk);
      bm.req_valid = 1'b0;
      checks++;
      if ({bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.out_count} !== {1'b1, 4'd0, 5'd1, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL msb_held_req: got v=%0b idx=%0d sel=%0d last=%0b cnt=%0d, expected 1 0 1 1 0",
                  bm.out_valid, bm.out_idx, bm.out_sel, bm.out_last, bm.out_count);
      end
      @(negedge clk);
      checks++;
      if ({bm.out_valid, bm.done} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL msb_held_done: got v=%0b done=%0b, expected 0 1", bm.out_valid, bm.done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_backpressure();
      test_empty();
      test_reset_mid();
      test_msb_first();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
